// File: rtl/regs_sb_if.sv
// Bus between the MCPU control unit and the scoreboarded register file.
// The master drives addresses and strobes; the slave returns read data, hazards and the pending count.
interface regs_sb_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [AW-1:0]   R_addr_A;
    logic [AW-1:0]   R_addr_B;
    logic [DW-1:0]   rdata_A;
    logic [DW-1:0]   rdata_B;
    logic [AW-1:0]   Wt_addr;
    logic [DW-1:0]   Wt_data;
    logic [DW/8-1:0] Wt_be;
    logic            L_S;
    logic            Iss_valid;
    logic [AW-1:0]   Iss_addr;
    logic            Flush;
    logic            hazard_A;
    logic            hazard_B;
    logic [AW:0]     pend_cnt;

    modport master (
        output R_addr_A, R_addr_B, Wt_addr, Wt_data, Wt_be, L_S, Iss_valid, Iss_addr, Flush,
        input  rdata_A, rdata_B, hazard_A, hazard_B, pend_cnt
    );

    modport slave (
        input  R_addr_A, R_addr_B, Wt_addr, Wt_data, Wt_be, L_S, Iss_valid, Iss_addr, Flush,
        output rdata_A, rdata_B, hazard_A, hazard_B, pend_cnt
    );
endinterface

// File: rtl/regs_sb.sv
// Register file with two async read ports, one byte-enabled sync write port and a
// per-register pending scoreboard that flags read-after-write hazards.
module regs_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic      clk,
    input logic      rst,
    regs_sb_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [DW-1:0]    wr_merged;
    logic             wr_en;
    logic             iss_en;
    logic             wr_clear;
    logic [AW:0]      cnt;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Writes are gated by reset so nothing is forwarded while the file is held cleared.
    assign wr_en    = rst && bus.L_S && (bus.Wt_be != '0) && !is_zero(bus.Wt_addr);
    assign iss_en   = bus.Iss_valid && !is_zero(bus.Iss_addr);
    assign wr_clear = wr_en && !(iss_en && (bus.Iss_addr == bus.Wt_addr));

    always_comb begin
        wr_merged = regs_q[bus.Wt_addr];
        for (int k = 0; k < NB; k++) begin
            if (bus.Wt_be[k]) wr_merged[8*k +: 8] = bus.Wt_data[8*k +: 8];
        end
    end

    // Issue outranks the writeback clear so a back-to-back reissue stays pending.
    always_comb begin
        pend_d = pend_q;
        if (bus.Flush) begin
            pend_d = '0;
        end else begin
            if (wr_en)  pend_d[bus.Wt_addr]  = 1'b0;
            if (iss_en) pend_d[bus.Iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[bus.Wt_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend_q <= '0;
        else      pend_q <= pend_d;
    end

    assign bus.rdata_A = is_zero(bus.R_addr_A) ? '0 :
                         ((BYPASS != 0) && wr_en && (bus.Wt_addr == bus.R_addr_A)) ? wr_merged :
                         regs_q[bus.R_addr_A];
    assign bus.rdata_B = is_zero(bus.R_addr_B) ? '0 :
                         ((BYPASS != 0) && wr_en && (bus.Wt_addr == bus.R_addr_B)) ? wr_merged :
                         regs_q[bus.R_addr_B];

    assign bus.hazard_A = !is_zero(bus.R_addr_A) && pend_q[bus.R_addr_A] &&
                          !((BYPASS != 0) && wr_clear && (bus.Wt_addr == bus.R_addr_A));
    assign bus.hazard_B = !is_zero(bus.R_addr_B) && pend_q[bus.R_addr_B] &&
                          !((BYPASS != 0) && wr_clear && (bus.Wt_addr == bus.R_addr_B));

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) cnt = cnt + (AW+1)'(pend_q[i]);
    end
    assign bus.pend_cnt = cnt;
endmodule

// File: tb/tb_regs_sb.sv
// Directed bench for regs_sb: a bypassing and a non-bypassing instance share one stimulus
// stream and are compared every cycle against a register/pending-set model.
module tb_regs_sb;
  logic clk;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  regs_sb_if #(.DW(32), .AW(5)) if_a ();
  regs_sb_if #(.DW(32), .AW(5)) if_b ();

  regs_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  regs_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  assign if_b.R_addr_A  = if_a.R_addr_A;
  assign if_b.R_addr_B  = if_a.R_addr_B;
  assign if_b.Wt_addr   = if_a.Wt_addr;
  assign if_b.Wt_data   = if_a.Wt_data;
  assign if_b.Wt_be     = if_a.Wt_be;
  assign if_b.L_S       = if_a.L_S;
  assign if_b.Iss_valid = if_a.Iss_valid;
  assign if_b.Iss_addr  = if_a.Iss_addr;
  assign if_b.Flush     = if_a.Flush;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: register contents plus the set of pending registers
  logic [31:0] m_reg [32];
  bit          m_pend [32];

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
    return r;
  endfunction

  function automatic bit m_writing(input int a);
    return rst && if_a.L_S && (if_a.Wt_be != 4'b0) && (if_a.Wt_addr != 0) && (int'(if_a.Wt_addr) == a);
  endfunction

  function automatic logic [31:0] exp_rd(input int a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && m_writing(a)) return merge(m_reg[a], if_a.Wt_data, if_a.Wt_be);
    return m_reg[a];
  endfunction

  function automatic logic exp_hz(input int a, input bit byp);
    bit clearing;
    if (a == 0) return 1'b0;
    clearing = m_writing(a) && !(if_a.Iss_valid && int'(if_a.Iss_addr) == a);
    return m_pend[a] && !(byp && clearing);
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'h0;
        m_pend[i] = 1'b0;
      end
    end else begin
      for (int a = 1; a < 32; a++) begin
        if (if_a.Flush)                                    m_pend[a] = 1'b0;
        else if (if_a.Iss_valid && int'(if_a.Iss_addr) == a) m_pend[a] = 1'b1;
        else if (m_writing(a))                             m_pend[a] = 1'b0;
      end
      for (int a = 1; a < 32; a++)
        if (m_writing(a)) m_reg[a] = merge(m_reg[a], if_a.Wt_data, if_a.Wt_be);
    end
  end

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("a.rdata_A",  if_a.rdata_A,  exp_rd(int'(if_a.R_addr_A), 1'b1));
    chk("a.rdata_B",  if_a.rdata_B,  exp_rd(int'(if_a.R_addr_B), 1'b1));
    chk("a.hazard_A", 32'(if_a.hazard_A), 32'(exp_hz(int'(if_a.R_addr_A), 1'b1)));
    chk("a.hazard_B", 32'(if_a.hazard_B), 32'(exp_hz(int'(if_a.R_addr_B), 1'b1)));
    chk("a.pend_cnt", 32'(if_a.pend_cnt), 32'(exp_cnt()));
    chk("b.rdata_A",  if_b.rdata_A,  exp_rd(int'(if_a.R_addr_A), 1'b0));
    chk("b.rdata_B",  if_b.rdata_B,  exp_rd(int'(if_a.R_addr_B), 1'b0));
    chk("b.hazard_A", 32'(if_b.hazard_A), 32'(exp_hz(int'(if_a.R_addr_A), 1'b0)));
    chk("b.hazard_B", 32'(if_b.hazard_B), 32'(exp_hz(int'(if_a.R_addr_B), 1'b0)));
    chk("b.pend_cnt", 32'(if_b.pend_cnt), 32'(exp_cnt()));
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_a.L_S = 1'b0; if_a.Iss_valid = 1'b0; if_a.Flush = 1'b0;
  endtask

  task automatic write(input int a, input logic [31:0] d, input logic [3:0] be);
    if_a.L_S = 1'b1; if_a.Wt_addr = 5'(a); if_a.Wt_data = d; if_a.Wt_be = be;
  endtask

  task automatic issue(input int a);
    if_a.Iss_valid = 1'b1; if_a.Iss_addr = 5'(a);
  endtask

  initial begin
    rst = 1'b0;
    if_a.R_addr_A = '0; if_a.R_addr_B = '0; if_a.Wt_addr = '0; if_a.Wt_data = '0;
    if_a.Wt_be = '0; if_a.Iss_addr = '0;
    idle();
    step(); step();
    rst = 1'b1;
    step();
    #2 chk("lit.reset_cnt", 32'(if_a.pend_cnt), 32'd0);

    write(5, 32'hDEADBEEF, 4'hF); step(); idle();
    if_a.R_addr_A = 5; #2 chk("lit.r5", if_a.rdata_A, 32'hDEADBEEF);

    write(7, 32'h11223344, 4'hF); step();
    write(7, 32'hAABBCCDD, 4'h5); step(); idle();
    if_a.R_addr_A = 7; #2 chk("lit.r7_be", if_a.rdata_A, 32'h11BB33DD);

    write(0, 32'hFFFFFFFF, 4'hF); step(); idle();
    if_a.R_addr_A = 0; #2 chk("lit.r0", if_a.rdata_A, 32'h0);

    write(3, 32'h00000055, 4'hF); if_a.R_addr_B = 3;
    #2 chk("lit.byp_a", if_a.rdata_B, 32'h55);
    chk("lit.nobyp_b_old", if_b.rdata_B, 32'h0);
    step(); idle();
    #2 chk("lit.nobyp_b_new", if_b.rdata_B, 32'h55);

    issue(9); if_a.R_addr_A = 9;
    #2 chk("lit.iss_same_cycle", 32'(if_a.hazard_A), 32'd0);
    step(); idle();
    #2 chk("lit.r9_hazard", 32'(if_a.hazard_A), 32'd1);
    chk("lit.r9_cnt", 32'(if_a.pend_cnt), 32'd1);
    write(9, 32'h99, 4'hF);
    #2 chk("lit.wb_byp_hz", 32'(if_a.hazard_A), 32'd0);
    chk("lit.wb_nobyp_hz", 32'(if_b.hazard_A), 32'd1);
    step(); idle();
    #2 chk("lit.wb_cnt", 32'(if_a.pend_cnt), 32'd0);

    issue(4); step(); idle();
    issue(4); write(4, 32'h44, 4'h3); step(); idle();
    if_a.R_addr_A = 4;
    #2 chk("lit.reissue_cnt", 32'(if_a.pend_cnt), 32'd1);
    chk("lit.reissue_hz", 32'(if_a.hazard_A), 32'd1);

    if_a.Flush = 1'b1; issue(6); step(); idle();
    if_a.R_addr_A = 6;
    #2 chk("lit.flush_cnt", 32'(if_a.pend_cnt), 32'd0);
    chk("lit.flush_r6", 32'(if_a.hazard_A), 32'd0);

    for (int i = 10; i < 21; i++) begin
      write(i, 32'h01010101 * i, 4'(i));
      if_a.R_addr_A = 5'(i); if_a.R_addr_B = 5'(i - 1);
      step();
    end
    idle();

    for (int i = 1; i < 32; i++) begin
      issue(i); if_a.R_addr_A = 5'(i); step();
    end
    issue(0); step(); idle();
    #2 chk("lit.fill_cnt", 32'(if_a.pend_cnt), 32'd31);
    if_a.Flush = 1'b1; step(); idle();
    if_a.R_addr_A = 5; if_a.R_addr_B = 7;
    #2 chk("lit.fill_flush", 32'(if_a.pend_cnt), 32'd0);
    chk("lit.keep_r5", if_a.rdata_A, 32'hDEADBEEF);
    chk("lit.keep_r7", if_a.rdata_B, 32'h11BB33DD);

    issue(12); step(); idle();
    #2 rst = 1'b0;
    #1 chk("lit.rst_rdata", if_a.rdata_A, 32'h0);
    chk("lit.rst_cnt", 32'(if_a.pend_cnt), 32'd0);
    write(8, 32'h88888888, 4'hF); issue(8);
    step();
    idle(); rst = 1'b1;
    step();
    if_a.R_addr_A = 8;
    #2 chk("lit.rst_drop_wr", if_a.rdata_A, 32'h0);
    chk("lit.rst_drop_iss", 32'(if_a.pend_cnt), 32'd0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
